// File: rtl/servant_wb_arbiter.sv
// Two-initiator to one-target Wishbone arbiter with registered round-robin/fixed-priority grant.
// Optional grant watchdog enabled by defining SERVANT_WB_ARB_TIMEOUT_EN.
module servant_wb_arbiter #(
    parameter int unsigned RR      = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_wb_m0_adr,
    input  logic [31:0] i_wb_m0_dat,
    input  logic [3:0]  i_wb_m0_sel,
    input  logic        i_wb_m0_we,
    input  logic        i_wb_m0_cyc,
    output logic [31:0] o_wb_m0_rdt,
    output logic        o_wb_m0_ack,
    input  logic [31:0] i_wb_m1_adr,
    input  logic [31:0] i_wb_m1_dat,
    input  logic [3:0]  i_wb_m1_sel,
    input  logic        i_wb_m1_we,
    input  logic        i_wb_m1_cyc,
    output logic [31:0] o_wb_m1_rdt,
    output logic        o_wb_m1_ack,
    output logic [31:0] o_wb_s_adr,
    output logic [31:0] o_wb_s_dat,
    output logic [3:0]  o_wb_s_sel,
    output logic        o_wb_s_we,
    output logic        o_wb_s_cyc,
    input  logic [31:0] i_wb_s_rdt,
    input  logic        i_wb_s_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   owner_cyc;
    logic   to_hit;

    always_comb begin
        owner_cyc = 1'b0;
        case (state_q)
            GNT0:    owner_cyc = i_wb_m0_cyc;
            GNT1:    owner_cyc = i_wb_m1_cyc;
            default: owner_cyc = 1'b0;
        endcase
    end

`ifdef SERVANT_WB_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Target ack in the same cycle wins over the watchdog.
    assign to_hit = owner_cyc && !i_wb_s_ack && (cnt_q == CW'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!i_wb_s_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign to_hit         = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        o_wb_s_adr  = i_wb_m0_adr;
        o_wb_s_dat  = i_wb_m0_dat;
        o_wb_s_sel  = i_wb_m0_sel;
        o_wb_s_we   = i_wb_m0_we;
        o_wb_s_cyc  = owner_cyc && !to_hit;
        o_wb_m0_ack = 1'b0;
        o_wb_m1_ack = 1'b0;
        o_wb_m0_rdt = to_hit ? 32'hDEADBEEF : i_wb_s_rdt;
        o_wb_m1_rdt = to_hit ? 32'hDEADBEEF : i_wb_s_rdt;

        case (state_q)
            IDLE: begin
                if (i_wb_m0_cyc && i_wb_m1_cyc) begin
                    state_d = ((RR != 0) && !last_q) ? GNT1 : GNT0;
                end else if (i_wb_m0_cyc) begin
                    state_d = GNT0;
                end else if (i_wb_m1_cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                o_wb_m0_ack = i_wb_s_ack || to_hit;
                if (i_wb_s_ack || !i_wb_m0_cyc || to_hit) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            GNT1: begin
                o_wb_s_adr  = i_wb_m1_adr;
                o_wb_s_dat  = i_wb_m1_dat;
                o_wb_s_sel  = i_wb_m1_sel;
                o_wb_s_we   = i_wb_m1_we;
                o_wb_m1_ack = i_wb_s_ack || to_hit;
                if (i_wb_s_ack || !i_wb_m1_cyc || to_hit) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_servant_wb_arbiter.sv
// Directed bench for servant_wb_arbiter: one round-robin and one fixed-priority instance on shared inputs.
module tb_servant_wb_arbiter;

    localparam logic [31:0] A0 = 32'hA000_0000;
    localparam logic [31:0] A1 = 32'hB000_0000;
    localparam logic [31:0] D0 = 32'h0D0D_0000;
    localparam logic [31:0] D1 = 32'h1D1D_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0c, m1c, s_ack, m0we, m1we;
    logic [31:0] s_rdt;

    logic [31:0] rr_m0_rdt, rr_m1_rdt, rr_s_adr, rr_s_dat;
    logic        rr_m0_ack, rr_m1_ack, rr_s_we, rr_s_cyc;
    logic [3:0]  rr_s_sel;
    logic [31:0] fp_m0_rdt, fp_m1_rdt, fp_s_adr, fp_s_dat;
    logic        fp_m0_ack, fp_m1_ack, fp_s_we, fp_s_cyc;
    logic [3:0]  fp_s_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    servant_wb_arbiter #(.RR(1), .TIMEOUT(8)) dut_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_m0_adr(A0), .i_wb_m0_dat(D0), .i_wb_m0_sel(4'h3), .i_wb_m0_we(m0we),
        .i_wb_m0_cyc(m0c), .o_wb_m0_rdt(rr_m0_rdt), .o_wb_m0_ack(rr_m0_ack),
        .i_wb_m1_adr(A1), .i_wb_m1_dat(D1), .i_wb_m1_sel(4'hC), .i_wb_m1_we(m1we),
        .i_wb_m1_cyc(m1c), .o_wb_m1_rdt(rr_m1_rdt), .o_wb_m1_ack(rr_m1_ack),
        .o_wb_s_adr(rr_s_adr), .o_wb_s_dat(rr_s_dat), .o_wb_s_sel(rr_s_sel),
        .o_wb_s_we(rr_s_we), .o_wb_s_cyc(rr_s_cyc),
        .i_wb_s_rdt(s_rdt), .i_wb_s_ack(s_ack)
    );

    servant_wb_arbiter #(.RR(0), .TIMEOUT(8)) dut_fp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_m0_adr(A0), .i_wb_m0_dat(D0), .i_wb_m0_sel(4'h3), .i_wb_m0_we(m0we),
        .i_wb_m0_cyc(m0c), .o_wb_m0_rdt(fp_m0_rdt), .o_wb_m0_ack(fp_m0_ack),
        .i_wb_m1_adr(A1), .i_wb_m1_dat(D1), .i_wb_m1_sel(4'hC), .i_wb_m1_we(m1we),
        .i_wb_m1_cyc(m1c), .o_wb_m1_rdt(fp_m1_rdt), .o_wb_m1_ack(fp_m1_ack),
        .o_wb_s_adr(fp_s_adr), .o_wb_s_dat(fp_s_dat), .o_wb_s_sel(fp_s_sel),
        .o_wb_s_we(fp_s_we), .o_wb_s_cyc(fp_s_cyc),
        .i_wb_s_rdt(s_rdt), .i_wb_s_ack(s_ack)
    );

    typedef struct {
        logic        m0c;
        logic        m1c;
        logic        ack;
        logic [31:0] rdt;
        logic        ecyc;
        logic [31:0] eadr;
        logic        em0a;
        logic        em1a;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Pulse reset across two clock edges; returns at posedge+1 with state IDLE, last=1.
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fp_acks;

        rst_n = 1'b0; m0c = 1'b0; m1c = 1'b0; s_ack = 1'b0; s_rdt = '0;
        m0we = 1'b0; m1we = 1'b1;

        //           m0c  m1c  ack  rdt           cyc  adr  m0a  m1a
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, A0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, A0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, A0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, A0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h12345678, 1'b1, A0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, A0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, A0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, A1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'h11110000, 1'b1, A1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, A0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h22220000, 1'b1, A0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, A0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, A1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, A1, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, A0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, A0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, A0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, A0, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 32'h33333333, 1'b0, A0, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, A0, 1'b0, 1'b0};

        #2;
        chk("reset_cyc",    {31'b0, rr_s_cyc},  32'd0);
        chk("reset_m0_ack", {31'b0, rr_m0_ack}, 32'd0);
        chk("reset_m1_ack", {31'b0, rr_m1_ack}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin table: one row per clock, outputs sampled on the falling edge.
        for (int i = 0; i < 20; i++) begin
            m0c = tbl[i].m0c; m1c = tbl[i].m1c; s_ack = tbl[i].ack; s_rdt = tbl[i].rdt;
            @(negedge clk);
            chk($sformatf("row%0d_cyc", i),    {31'b0, rr_s_cyc},  {31'b0, tbl[i].ecyc});
            chk($sformatf("row%0d_adr", i),    rr_s_adr,           tbl[i].eadr);
            chk($sformatf("row%0d_m0ack", i),  {31'b0, rr_m0_ack}, {31'b0, tbl[i].em0a});
            chk($sformatf("row%0d_m1ack", i),  {31'b0, rr_m1_ack}, {31'b0, tbl[i].em1a});
            chk($sformatf("row%0d_m0rdt", i),  rr_m0_rdt,          tbl[i].rdt);
            chk($sformatf("row%0d_m1rdt", i),  rr_m1_rdt,          tbl[i].rdt);
            next_cycle();
        end

        // Async reset in the middle of a GNT0 cycle, then both pending after release.
        m0c = 1'b1; m1c = 1'b0; s_ack = 1'b0; s_rdt = 32'h0;
        next_cycle();
        s_ack = 1'b1;
        #1;
        chk("pre_rst_cyc",   {31'b0, rr_s_cyc},  32'd1);
        chk("pre_rst_m0ack", {31'b0, rr_m0_ack}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_cyc",   {31'b0, rr_s_cyc},  32'd0);
        chk("async_rst_m0ack", {31'b0, rr_m0_ack}, 32'd0);
        s_ack = 1'b0; m1c = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle_cyc", {31'b0, rr_s_cyc}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("post_rst_gnt0_cyc", {31'b0, rr_s_cyc}, 32'd1);
        chk("post_rst_gnt0_adr", rr_s_adr, A0);
        chk("post_rst_gnt0_dat", rr_s_dat, D0);
        s_ack = 1'b1; s_rdt = 32'hCAFE0000;
        #1;
        chk("post_rst_m0ack", {31'b0, rr_m0_ack}, 32'd1);
        chk("post_rst_m1ack", {31'b0, rr_m1_ack}, 32'd0);
        next_cycle();
        s_ack = 1'b0;
        @(negedge clk);
        chk("rr_gap_cyc", {31'b0, rr_s_cyc}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rr_m1_cyc", {31'b0, rr_s_cyc}, 32'd1);
        chk("rr_m1_adr", rr_s_adr, A1);
        chk("rr_m1_dat", rr_s_dat, D1);
        chk("rr_m1_sel", {28'b0, rr_s_sel}, 32'hC);
        chk("rr_m1_we",  {31'b0, rr_s_we},  32'd1);
        m0c = 1'b0; m1c = 1'b0;

        // Fixed priority: both request continuously, target acks every granted cycle.
        do_reset();
        m0c = 1'b1; m1c = 1'b1;
        fp_acks = 0;
        for (int k = 0; k < 8; k++) begin
            s_ack = (k % 2 == 1);
            @(negedge clk);
            chk($sformatf("fp%0d_cyc", k),   {31'b0, fp_s_cyc},  (k % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("fp%0d_m0ack", k), {31'b0, fp_m0_ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("fp%0d_m1ack", k), {31'b0, fp_m1_ack}, 32'd0);
            if (k % 2 == 1) chk($sformatf("fp%0d_adr", k), fp_s_adr, A0);
            if (fp_m0_ack) fp_acks++;
            next_cycle();
        end
        chk("fp_total_m0_acks", fp_acks, 32'd4);
        s_ack = 1'b0; m0c = 1'b0; m1c = 1'b0;

`ifdef SERVANT_WB_ARB_TIMEOUT_EN
        // Watchdog: m0 write never acked, forced termination 8 cycles after grant.
        do_reset();
        m0c = 1'b1; m0we = 1'b1; m1c = 1'b1; s_ack = 1'b0; s_rdt = 32'h0;
        @(negedge clk);
        chk("to_idle_cyc", {31'b0, rr_s_cyc}, 32'd0);
        for (int j = 1; j <= 8; j++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("to_wait%0d_cyc", j),   {31'b0, rr_s_cyc},  32'd1);
            chk($sformatf("to_wait%0d_m0ack", j), {31'b0, rr_m0_ack}, 32'd0);
        end
        next_cycle();
        @(negedge clk);
        chk("to_hit_m0ack", {31'b0, rr_m0_ack}, 32'd1);
        chk("to_hit_rdt",   rr_m0_rdt,          32'hDEADBEEF);
        chk("to_hit_cyc",   {31'b0, rr_s_cyc},  32'd0);
        chk("to_hit_m1ack", {31'b0, rr_m1_ack}, 32'd0);
        next_cycle();
        m0c = 1'b0;
        @(negedge clk);
        chk("to_after_idle", {31'b0, rr_s_cyc}, 32'd0);
        next_cycle();
        s_ack = 1'b1; s_rdt = 32'h55555555;
        @(negedge clk);
        chk("to_m1_adr",   rr_s_adr,           A1);
        chk("to_m1_ack",   {31'b0, rr_m1_ack}, 32'd1);
        chk("to_m1_rdt",   rr_m1_rdt,          32'h55555555);
        next_cycle();
        s_ack = 1'b0; m1c = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
